// File: rtl/pixel_clk_pkg.sv
// Purpose: shared types, defaults and the INC/MOD mode table for pixel_clk_gen.
// Latency: n/a (constants and one pure lookup helper).
// Backpressure: n/a.
package pixel_clk_pkg;

   localparam int ACC_W_DEFAULT        = 12;
   localparam int LOCK_STROBES_DEFAULT = 16;
   localparam int MODE_TABLE_SIZE      = 4;

   // Index into the mode table; sized for the full table.
   typedef logic [1:0] mode_idx_t;

   // Strobe rate of mode m is MODE_INC[m] / MODE_MOD[m] of the 50 MHz clock.
   //   0: 1/2        -> 25.000 MHz
   //   1: 1007/2000  -> 25.175 MHz
   //   2: 4/5        -> 40.000 MHz
   //   3: 27/50      -> 27.000 MHz
   localparam int unsigned MODE_INC [MODE_TABLE_SIZE] = '{1, 1007, 4, 27};
   localparam int unsigned MODE_MOD [MODE_TABLE_SIZE] = '{2, 2000, 5, 50};

   function automatic int unsigned mode_inc(input mode_idx_t m);
      return MODE_INC[m];
   endfunction

   function automatic int unsigned mode_mod(input mode_idx_t m);
      return MODE_MOD[m];
   endfunction

endpackage

// File: rtl/pixel_clk_gen_frac_accum.sv
// Purpose: fractional phase accumulator; wrap fires when acc + inc reaches mod.
// Latency: wrap is combinational from the registered acc; acc updates each clk.
// Backpressure: none; free-running, clr forces acc to zero on the next edge.
// The next-acc output exists only when CLK_PIXEL_OUT_EN is defined.
module frac_accum #(
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [ACC_W-1:0] inc,
   input  logic [ACC_W-1:0] mod,
`ifdef CLK_PIXEL_OUT_EN
   output logic [ACC_W-1:0] acc_nxt,
`endif
   output logic             wrap
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W:0]   sum;

   // One extra bit on the sum so acc + inc never overflows before the compare.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, inc};
      wrap  = (sum >= {1'b0, mod});
      acc_d = wrap ? ACC_W'(sum - {1'b0, mod}) : sum[ACC_W-1:0];
      if (clr) begin
         acc_d = '0;
      end
   end

`ifdef CLK_PIXEL_OUT_EN
   assign acc_nxt = acc_d;
`endif

   // Phase register.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/pixel_clk_gen.sv
// Purpose: pixel-strobe generator with runtime mode switch, lock flag and optional clk_pixel.
// Latency: pix_stb is registered one cycle after the accumulator wrap decision.
// Backpressure: mode_load is dropped while mode_busy is high or mode_sel is out of range.
// Build option: CLK_PIXEL_OUT_EN enables the clk_pixel register; otherwise clk_pixel is 0.
module pixel_clk_gen
   import pixel_clk_pkg::*;
#(
   parameter int ACC_W        = ACC_W_DEFAULT,
   parameter int NUM_MODES    = 4,
   parameter int DEFAULT_MODE = 0,
   parameter int LOCK_STROBES = LOCK_STROBES_DEFAULT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [$clog2(NUM_MODES)-1:0] mode_sel,
   input  logic                         mode_load,
   output logic                         mode_busy,
   output logic [$clog2(NUM_MODES)-1:0] cur_mode,
   output logic                         pix_stb,
   output logic                         clk_pixel,
   output logic                         locked
);

   localparam int MODE_W = $clog2(NUM_MODES);
   localparam int LCW    = $clog2(LOCK_STROBES + 1);

   logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
   logic [MODE_W-1:0] pend_q, pend_d;
   logic              busy_q, busy_d;
   logic              stb_q, stb_d;
   logic              locked_q, locked_d;
   logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;

   logic [ACC_W-1:0]  inc;
   logic [ACC_W-1:0]  mod;
   logic              wrap;
   logic              accept;
   logic              apply;

   // Rate constants for the mode currently in effect.
   always_comb begin
      inc = ACC_W'(mode_inc(mode_idx_t'(cur_mode_q)));
      mod = ACC_W'(mode_mod(mode_idx_t'(cur_mode_q)));
   end

`ifdef CLK_PIXEL_OUT_EN
   logic [ACC_W-1:0] acc_nxt;
   logic             clk_pixel_q, clk_pixel_d;
`endif

   frac_accum #(
      .ACC_W (ACC_W)
   ) u_accum (
      .clk     (clk),
      .reset   (reset),
      .clr     (apply),
      .inc     (inc),
      .mod     (mod),
`ifdef CLK_PIXEL_OUT_EN
      .acc_nxt (acc_nxt),
`endif
      .wrap    (wrap)
   );

   // Handshake: latch a valid request when idle; apply it on the next wrap so
   // the switch lands on a strobe boundary and that cycle's strobe survives.
   always_comb begin
      accept     = mode_load && !busy_q && (int'(mode_sel) < NUM_MODES);
      apply      = busy_q && wrap;
      cur_mode_d = cur_mode_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      if (apply) begin
         cur_mode_d = pend_q;
         busy_d     = 1'b0;
      end else if (accept) begin
         pend_d = mode_sel;
         busy_d = 1'b1;
      end
   end

   // Lock: count wraps under the current mode; locked tracks the saturated count.
   always_comb begin
      stb_d      = wrap;
      lock_cnt_d = lock_cnt_q;
      if (apply) begin
         lock_cnt_d = '0;
      end else if (wrap && !locked_q && (lock_cnt_q != LCW'(LOCK_STROBES))) begin
         lock_cnt_d = lock_cnt_q + 1'b1;
      end
      locked_d = (lock_cnt_d == LCW'(LOCK_STROBES));
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_mode_q <= MODE_W'(DEFAULT_MODE);
         pend_q     <= MODE_W'(DEFAULT_MODE);
         busy_q     <= 1'b0;
         stb_q      <= 1'b0;
         locked_q   <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         cur_mode_q <= cur_mode_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         stb_q      <= stb_d;
         locked_q   <= locked_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

`ifdef CLK_PIXEL_OUT_EN
   // High for the upper half of the phase range, giving roughly 50% duty.
   always_comb begin
      clk_pixel_d = (acc_nxt >= (mod >> 1));
   end

   // Pixel clock register.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_pixel_q <= 1'b0;
      end else begin
         clk_pixel_q <= clk_pixel_d;
      end
   end

   assign clk_pixel = clk_pixel_q;
`else
   assign clk_pixel = 1'b0;
`endif

   assign mode_busy = busy_q;
   assign cur_mode  = cur_mode_q;
   assign pix_stb   = stb_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_pixel_clk_gen.sv
// Directed bench for pixel_clk_gen: cadence, rates, handshake, lock and reset.
module tb_pixel_clk_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode_load, mode_load3;
   logic [1:0] mode_sel, mode_sel3;
   logic       mode_busy, pix_stb, clk_pixel, locked;
   logic [1:0] cur_mode;
   logic       mode_busy3, pix_stb3, clk_pixel3, locked3;
   logic [1:0] cur_mode3;

   int errors = 0;
   int checks = 0;

`ifdef CLK_PIXEL_OUT_EN
   localparam bit CP_EN = 1'b1;
`else
   localparam bit CP_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   pixel_clk_gen dut (
      .clk       (clk),
      .reset     (reset),
      .mode_sel  (mode_sel),
      .mode_load (mode_load),
      .mode_busy (mode_busy),
      .cur_mode  (cur_mode),
      .pix_stb   (pix_stb),
      .clk_pixel (clk_pixel),
      .locked    (locked)
   );

   pixel_clk_gen #(.NUM_MODES(3)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .mode_sel  (mode_sel3),
      .mode_load (mode_load3),
      .mode_busy (mode_busy3),
      .cur_mode  (cur_mode3),
      .pix_stb   (pix_stb3),
      .clk_pixel (clk_pixel3),
      .locked    (locked3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int n, cnt, since, maxgap, bad, lowcnt, total, badcp;

      reset = 1'b1; mode_load = 1'b0; mode_sel = 2'd0;
      mode_load3 = 1'b0; mode_sel3 = 2'd0;
      repeat (3) tick();
      chk("rst_stb",   pix_stb,   0);
      chk("rst_cp",    clk_pixel, 0);
      chk("rst_lock",  locked,    0);
      chk("rst_busy",  mode_busy, 0);
      chk("rst_mode",  cur_mode,  0);

      // Mode 0 cadence and first lock.
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk("m0_stb",  pix_stb,   32'((k % 2) == 0));
         chk("m0_cp",   clk_pixel, 32'(CP_EN && ((k % 2) == 1)));
         chk("m0_lock", locked,    32'(k == 32));
      end

      // Switch to mode 1 from a non-wrap cycle; apply lands on the next wrap.
      mode_sel = 2'd1; mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      chk("ld1_busy", mode_busy, 1);
      chk("ld1_mode", cur_mode,  0);
      chk("ld1_stb",  pix_stb,   0);
      tick();
      chk("ap1_mode", cur_mode,  1);
      chk("ap1_busy", mode_busy, 0);
      chk("ap1_lock", locked,    0);
      chk("ap1_stb",  pix_stb,   1);
      n = 0;
      while (!locked && n < 200) begin tick(); n++; end
      chk("m1_locked", locked, 1);

      cnt = 0; since = 0; maxgap = 0; badcp = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         since++;
         if (pix_stb) begin
            cnt++;
            if (since > maxgap) maxgap = since;
            since = 0;
         end
         if (!CP_EN && clk_pixel !== 1'b0) badcp++;
      end
      chk("m1_count_2000", cnt, 1007);
      chk("m1_gap_le2",    32'(maxgap <= 2), 1);

      // Mode 2: four strobes in every five-cycle window.
      mode_sel = 2'd2; mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      chk("ld2_busy", mode_busy, 1);
      n = 0;
      while (mode_busy && n < 10) begin tick(); n++; end
      chk("ap2_mode", cur_mode,  2);
      chk("ap2_busy", mode_busy, 0);
      bad = 0; total = 0;
      for (int w = 0; w < 100; w++) begin
         cnt = 0;
         for (int j = 0; j < 5; j++) begin
            tick();
            if (pix_stb) cnt++;
            if (!CP_EN && clk_pixel !== 1'b0) badcp++;
         end
         total += cnt;
         if (cnt != 4) bad++;
      end
      chk("m2_bad_windows", bad,   0);
      chk("m2_total",       total, 400);

      // Load while busy is dropped and leaves the pending index alone.
      mode_sel = 2'd0; mode_load = 1'b1;
      tick();
      chk("ign_busy_set", mode_busy, 1);
      mode_sel = 2'd1;
      tick();
      mode_load = 1'b0;
      chk("ign_mode", cur_mode,  0);
      chk("ign_busy", mode_busy, 0);

      // Load on a wrap cycle: latch now, apply on the following wrap (0 -> 3).
      tick();
      mode_sel = 2'd3; mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      chk("sw3_busy_a", mode_busy, 1);
      chk("sw3_mode_a", cur_mode,  0);
      chk("sw3_stb_a",  pix_stb,   1);
      tick();
      chk("sw3_busy_b", mode_busy, 1);
      chk("sw3_mode_b", cur_mode,  0);
      chk("sw3_stb_b",  pix_stb,   0);
      tick();
      chk("sw3_mode_c", cur_mode,  3);
      chk("sw3_busy_c", mode_busy, 0);
      chk("sw3_stb_c",  pix_stb,   1);
      chk("sw3_lock_c", locked,    0);
      lowcnt = 1;
      n = 0;
      while (!locked && n < 300) begin
         tick(); n++;
         if (!locked && pix_stb) lowcnt++;
      end
      chk("m3_locked",   locked, 1);
      chk("m3_low_stbs", lowcnt, 16);
      for (int w = 0; w < 3; w++) begin
         cnt = 0;
         for (int j = 0; j < 50; j++) begin
            tick();
            if (pix_stb) cnt++;
            if (!CP_EN && clk_pixel !== 1'b0) badcp++;
         end
         chk("m3_window_50", cnt, 27);
      end
      chk("cp_tied_low", badcp, 0);

      // Reset while a switch is pending.
      mode_sel = 2'd1; mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      chk("rb_busy", mode_busy, 1);
      reset = 1'b1;
      tick();
      chk("rb_stb",  pix_stb,   0);
      chk("rb_cp",   clk_pixel, 0);
      chk("rb_lock", locked,    0);
      chk("rb_busy0", mode_busy, 0);
      chk("rb_mode", cur_mode,  0);
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("rb_m0_stb",  pix_stb,   32'((k % 2) == 0));
         chk("rb_m0_cp",   clk_pixel, 32'(CP_EN && ((k % 2) == 1)));
         chk("rb_m0_mode", cur_mode,  0);
         chk("rb_m0_busy", mode_busy, 0);
      end

      // Three-mode instance: out-of-range index is ignored, in-range accepted.
      mode_sel3 = 2'd3; mode_load3 = 1'b1;
      tick();
      mode_load3 = 1'b0;
      chk("n3_oor_busy", mode_busy3, 0);
      chk("n3_oor_mode", cur_mode3,  0);
      mode_sel3 = 2'd2; mode_load3 = 1'b1;
      tick();
      mode_load3 = 1'b0;
      chk("n3_ok_busy", mode_busy3, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
